// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg: shared encodings for the MIPS memory-access stage.
//   - Size encodings for byte/half/word accesses (SZ_RSVD is the illegal code)
//   - FSM state enum for the mem_stage sequencer
//   - Bit positions of the M = {MemRead, MemWrite} and WB = {RegWrite, MemtoReg}
//     control vectors
//   - misaligned(): alignment check shared by the fault logic
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // True when the low address bits are illegal for the access size.
    // The reserved size code is always reported as a fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align: little-endian lane logic for the memory stage (purely combinational).
//   lane_i        address bits [1:0] of the access
//   size_i        access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   unsigned_i    1 = zero-extend loads, 0 = sign-extend
//   store_data_i  right-aligned store data
//   rdata_i       current contents of the addressed memory word
//   merged_o      word to write back: store bytes merged over rdata_i
//   load_o        extracted and extended load data (0 for the reserved size)
// -----------------------------------------------------------------------------
module mem_align
    import mips_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store path: byte enables plus store data replicated onto every lane.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: begin
                be_s    = 4'b0001 << lane_i;
                wdata_s = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                if (lane_i[1]) begin
                    be_s = 4'b1100;
                end else begin
                    be_s = 4'b0011;
                end
                wdata_s = {2{store_data_i[15:0]}};
            end
            SZ_WORD: begin
                be_s    = 4'b1111;
                wdata_s = store_data_i;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Merge enabled lanes over the old word so untouched lanes are preserved.
    always_comb begin
        merged_o = rdata_i;
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                merged_o[8*i +: 8] = wdata_s[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = rdata_i[8*i +: 8];
            end
        end
    end

    // Load path: select the addressed lane(s) and extend to 32 bits.
    always_comb begin
        byte_s = rdata_i[{lane_i, 3'b000} +: 8];
        if (lane_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (size_i)
            SZ_BYTE: begin
                if (unsigned_i) begin
                    load_o = {24'h00_0000, byte_s};
                end else begin
                    load_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_HALF: begin
                if (unsigned_i) begin
                    load_o = {16'h0000, half_s};
                end else begin
                    load_o = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_WORD: load_o = rdata_i;
            default: load_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: MIPS memory-access stage between EX/MEM and MEM/WB.
// Holds the data memory, zero-fills it after every reset, performs
// byte/half/word loads and stores, and latches a sticky fault on misaligned,
// reserved-size or out-of-range accesses, after which write-back is halted.
//   clk, rst        pipeline clock; synchronous active-high reset
//   ALUOut          byte address          StoreData  right-aligned store data
//   M               {MemRead, MemWrite}   Size       access size
//   Unsigned        zero-extend loads     RegWrIn/WBIn  write-back controls
//   MEM_DataAddr    ALUOut pass-through   MEM_DataRead  extended load data
//   MEM_RegWr/MEM_WB  gated write-back controls
//   Stall           freeze request (INIT fill or HALT)
//   Fault/FaultAddr sticky fault flag and address of the faulting access
// -----------------------------------------------------------------------------
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUOut,
    input  logic [31:0] StoreData,
    input  logic [1:0]  M,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [4:0]  RegWrIn,
    input  logic [1:0]  WBIn,
    output logic [31:0] MEM_DataAddr,
    output logic [31:0] MEM_DataRead,
    output logic [4:0]  MEM_RegWr,
    output logic [1:0]  MEM_WB,
    output logic        Stall,
    output logic        Fault,
    output logic [31:0] FaultAddr
);

    state_e         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           fault_q, fault_d;
    logic [31:0]    fault_addr_q, fault_addr_d;

    logic [31:0]    mem_q [DEPTH];

    logic [AW-1:0]  word_idx_s;
    logic [31:0]    rdata_s;
    logic [31:0]    merged_s;
    logic [31:0]    load_s;
    logic           mem_read_s;
    logic           mem_write_s;
    logic           out_of_range_s;
    logic           access_fault_s;
    logic           pass_s;
    logic           mem_we_s;
    logic [AW-1:0]  mem_widx_s;
    logic [31:0]    mem_wdata_s;

    assign word_idx_s  = ALUOut[AW+1:2];
    assign rdata_s     = mem_q[word_idx_s];
    assign mem_read_s  = M[M_READ];
    assign mem_write_s = M[M_WRITE];

    // Any set address bit above the memory window is a range fault.
    assign out_of_range_s = |ALUOut[31:AW+2];
    // Faults are only raised for real accesses while the stage is running.
    assign access_fault_s = (state_q == ST_RUN) && (|M) &&
                            (misaligned(Size, ALUOut[1:0]) || out_of_range_s);
    assign pass_s = (state_q == ST_RUN) && !access_fault_s;

    mem_align u_align (
        .lane_i       (ALUOut[1:0]),
        .size_i       (Size),
        .unsigned_i   (Unsigned),
        .store_data_i (StoreData),
        .rdata_i      (rdata_s),
        .merged_o     (merged_s),
        .load_o       (load_s)
    );

    // Next-state logic for the fill sequencer, FSM and sticky fault capture.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (access_fault_s) begin
                    fault_d      = 1'b1;
                    fault_addr_d = ALUOut;
                    state_d      = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    // Memory write port: zero fill during INIT, merged store word during RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_widx_s  = idx_q;
        mem_wdata_s = 32'h0000_0000;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_widx_s  = idx_q;
                mem_wdata_s = 32'h0000_0000;
            end
            ST_RUN: begin
                if (mem_write_s && !access_fault_s) begin
                    mem_we_s    = 1'b1;
                    mem_widx_s  = word_idx_s;
                    mem_wdata_s = merged_s;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: mem_we_s = 1'b0;
        endcase
    end

    // Stage outputs: write-back controls and load data are gated by pass_s.
    always_comb begin
        MEM_DataAddr = ALUOut;
        MEM_WB       = 2'b00;
        MEM_RegWr    = 5'd0;
        MEM_DataRead = 32'h0000_0000;
        if (pass_s) begin
            MEM_WB[WB_REGWRITE] = WBIn[WB_REGWRITE];
            MEM_WB[WB_MEMTOREG] = WBIn[WB_MEMTOREG];
            MEM_RegWr           = RegWrIn;
            // MemWrite wins when both control bits are set.
            if (mem_read_s && !mem_write_s) begin
                MEM_DataRead = load_s;
            end else begin
                MEM_DataRead = 32'h0000_0000;
            end
        end else begin
            MEM_WB       = 2'b00;
            MEM_RegWr    = 5'd0;
            MEM_DataRead = 32'h0000_0000;
        end
    end

    assign Stall     = (state_q != ST_RUN);
    assign Fault     = fault_q;
    assign FaultAddr = fault_addr_q;

    // FSM, fill index and fault registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Data memory write; no writes happen while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_q[mem_widx_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: scoreboard bench for mem_stage (DEPTH=16).
// The driver applies one access per cycle, predicts the stage outputs from a
// byte-array memory model and pushes them into a queue; a monitor on the
// falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUOut, StoreData;
    logic [1:0]  M, Size;
    logic        Unsigned;
    logic [4:0]  RegWrIn;
    logic [1:0]  WBIn;
    logic [31:0] MEM_DataAddr, MEM_DataRead, FaultAddr;
    logic [4:0]  MEM_RegWr;
    logic [1:0]  MEM_WB;
    logic        Stall, Fault;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ALUOut(ALUOut), .StoreData(StoreData), .M(M),
        .Size(Size), .Unsigned(Unsigned), .RegWrIn(RegWrIn), .WBIn(WBIn),
        .MEM_DataAddr(MEM_DataAddr), .MEM_DataRead(MEM_DataRead),
        .MEM_RegWr(MEM_RegWr), .MEM_WB(MEM_WB), .Stall(Stall), .Fault(Fault),
        .FaultAddr(FaultAddr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rd;
        logic [4:0]  rw;
        logic [1:0]  wb;
        logic        stall;
        logic        fault;
        logic [31:0] faddr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0]  mb [NBYTE];
    int          fill_rem = 0;
    bit          known = 1'b0;
    bit          halted = 1'b0;
    bit          m_fault = 1'b0;
    logic [31:0] m_faddr = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a, input logic [1:0] sz);
        if (a >= 32'(NBYTE)) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a);
        if (sz == 2'd0) begin
            b = mb[i];
            return u ? {24'h0, b} : 32'($signed(b));
        end else if (sz == 2'd1) begin
            h = {mb[i+1], mb[i]};
            return u ? {16'h0, h} : 32'($signed(h));
        end
        return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
    endfunction

    // One pipeline cycle: drive, predict, push, clock, then advance the model.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] sd,
                        input logic [1:0] m, input logic [1:0] sz, input logic u,
                        input logic [4:0] rw, input logic [1:0] wb);
        exp_t e;
        bit   run, f;
        int   i;
        rst = r; ALUOut = a; StoreData = sd; M = m; Size = sz;
        Unsigned = u; RegWrIn = rw; WBIn = wb;
        run = known && (fill_rem == 0) && !halted;
        f   = run && (m != 2'b00) && is_fault(a, sz);
        e.addr  = a;
        e.stall = !run;
        e.fault = m_fault;
        e.faddr = m_faddr;
        e.wb    = (run && !f) ? wb : 2'b00;
        e.rw    = (run && !f) ? rw : 5'd0;
        e.rd    = (run && !f && m == 2'b10) ? model_load(a, sz, u) : 32'h0;
        if (known) exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            known = 1'b1; fill_rem = DEPTH; halted = 1'b0;
            m_fault = 1'b0; m_faddr = 32'h0;
        end else if (fill_rem > 0) begin
            fill_rem--;
            if (fill_rem == 0) begin
                for (int k = 0; k < NBYTE; k++) mb[k] = 8'h00;
            end
        end else if (known && !halted) begin
            if (f) begin
                m_fault = 1'b1; m_faddr = a; halted = 1'b1;
            end else if (m[0]) begin
                i = int'(a);
                mb[i] = sd[7:0];
                if (sz != 2'd0) mb[i+1] = sd[15:8];
                if (sz == 2'd2) begin
                    mb[i+2] = sd[23:16];
                    mb[i+3] = sd[31:24];
                end
            end
        end
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] m,
                      input logic [1:0] sz, input logic u);
        step(1'b0, a, sd, m, sz, u, 5'd9, 2'b11);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) op(32'h0, 32'h0, 2'b00, 2'b10, 1'b0);
    endtask

    task automatic rand_op(input logic r);
        logic [31:0] a;
        logic [1:0]  sz;
        int          k;
        sz = 2'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
        if (sz == 2'd1) a = a + 32'($urandom_range(0, 1) * 2);
        k = $urandom_range(0, 59);
        if (k == 0) a = a + 32'($urandom_range(1, 3));
        if (k == 1) sz = 2'd3;
        if (k == 2) a = a | (32'h1 << $urandom_range(AW + 2, 31));
        step(r, a, $urandom, 2'($urandom_range(0, 3)), sz, 1'($urandom_range(0, 1)),
             5'($urandom), 2'($urandom));
    endtask

    // Monitor: compare every predicted cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("DataAddr",  MEM_DataAddr,       e.addr);
                chk("DataRead",  MEM_DataRead,       e.rd);
                chk("RegWr",     32'(MEM_RegWr),     32'(e.rw));
                chk("WB",        32'(MEM_WB),        32'(e.wb));
                chk("Stall",     32'(Stall),         32'(e.stall));
                chk("Fault",     32'(Fault),         32'(e.fault));
                chk("FaultAddr", FaultAddr,          e.faddr);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NBYTE; k++) mb[k] = 8'h00;
        // Reset and fill
        for (int k = 0; k < 3; k++) step(1'b1, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 2'b00);
        idle(DEPTH);
        op(32'h3C, 32'h0, 2'b10, 2'b10, 1'b0);
        // Word store then every load flavour
        op(32'h10, 32'h8899AABB, 2'b01, 2'b10, 1'b0);
        op(32'h13, 32'h0, 2'b10, 2'b00, 1'b0);
        op(32'h13, 32'h0, 2'b10, 2'b00, 1'b1);
        op(32'h12, 32'h0, 2'b10, 2'b01, 1'b0);
        op(32'h12, 32'h0, 2'b10, 2'b01, 1'b1);
        op(32'h10, 32'h0, 2'b10, 2'b10, 1'b0);
        // Partial stores
        op(32'h11, 32'hFFFFFF5A, 2'b01, 2'b00, 1'b0);
        op(32'h10, 32'h0, 2'b10, 2'b10, 1'b0);
        op(32'h12, 32'hFFFF1234, 2'b01, 2'b01, 1'b0);
        op(32'h10, 32'h0, 2'b10, 2'b10, 1'b0);
        op(32'h10, 32'h0, 2'b11, 2'b10, 1'b0);
        // Misaligned load faults; a later store is suppressed
        step(1'b0, 32'h06, 32'h0, 2'b10, 2'b10, 1'b0, 5'd4, 2'b10);
        op(32'h14, 32'hDEADBEEF, 2'b01, 2'b10, 1'b0);
        idle(2);
        // Reset, then out-of-range store
        step(1'b1, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 2'b00);
        idle(DEPTH);
        op(32'h14, 32'h0, 2'b10, 2'b10, 1'b0);
        op(32'h00, 32'hCAFEF00D, 2'b01, 2'b10, 1'b0);
        op(32'h40, 32'h11111111, 2'b01, 2'b10, 1'b0);
        idle(2);
        // Reset in HALT, again mid-fill, then verify every word is zero
        step(1'b1, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 2'b00);
        idle(8);
        step(1'b1, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 5'd0, 2'b00);
        idle(DEPTH);
        for (int k = 0; k < DEPTH; k++) op(32'(k * 4), 32'h0, 2'b10, 2'b10, 1'b0);
        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ((halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
                rand_op(1'b1);
            end else begin
                rand_op(1'b0);
            end
        end
        idle(1);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
